// File: rtl/fp_mul_pipe.sv
// Three-stage floating-point multiplier with RNE rounding, exception flags and valid/ready handshakes on both sides.
// Define FP_MUL_SUBNORMAL_EN for gradual underflow; leave it undefined to flush subnormals to zero.
module fp_mul_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   result,
  output logic                   overflow,
  output logic                   underflow,
  output logic                   invalid,
  output logic                   inexact
);
  localparam int XW   = EXP_W + 2;
  localparam int PW   = 2 * (MAN_W + 1);
  localparam int BIAS = (1 << (EXP_W - 1)) - 1;
  localparam int MAXE = (1 << EXP_W) - 1;

  logic v1, v2, ld1, ld2, ld3;
  assign ld3      = !out_valid | out_ready;
  assign ld2      = !v2 | ld3;
  assign ld1      = !v1 | ld2;
  assign in_ready = ld1;

  logic sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  assign {sa, ea, fa} = a;
  assign {sb, eb, fb} = b;

  logic a_zero, a_sub, a_inf, a_nan, b_zero, b_sub, b_inf, b_nan;
  assign a_zero = (ea == '0) && (fa == '0);
  assign a_sub  = (ea == '0) && (fa != '0);
  assign a_inf  = (&ea) && (fa == '0);
  assign a_nan  = (&ea) && (fa != '0);
  assign b_zero = (eb == '0) && (fb == '0);
  assign b_sub  = (eb == '0) && (fb != '0);
  assign b_inf  = (&eb) && (fb == '0);
  assign b_nan  = (&eb) && (fb != '0);

  logic [XW-1:0]  xa, xb;
  logic [MAN_W:0] ma, mb;
  logic           ftz_a, ftz_b;

`ifdef FP_MUL_SUBNORMAL_EN
  function automatic logic [XW-1:0] lzc(input logic [MAN_W-1:0] f);
    logic [XW-1:0] n;
    n = XW'(MAN_W);
    for (int i = 0; i < MAN_W; i++)
      if (f[i]) n = XW'(MAN_W - 1 - i);
    return n;
  endfunction

  // Move a subnormal's leading one into the hidden position; its exponent becomes 1 - shift.
  always_comb begin
    xa = {2'b00, ea};
    ma = {1'b1, fa};
    xb = {2'b00, eb};
    mb = {1'b1, fb};
    if (a_sub) begin
      xa = XW'(0) - lzc(fa);
      ma = {1'b0, fa} << (lzc(fa) + XW'(1));
    end
    if (b_sub) begin
      xb = XW'(0) - lzc(fb);
      mb = {1'b0, fb} << (lzc(fb) + XW'(1));
    end
  end
  assign ftz_a = 1'b0;
  assign ftz_b = 1'b0;
`else
  assign xa    = {2'b00, ea};
  assign ma    = {1'b1, fa};
  assign xb    = {2'b00, eb};
  assign mb    = {1'b1, fb};
  assign ftz_a = a_sub;
  assign ftz_b = b_sub;
`endif

  logic c_nan, c_inf, c_zero, c_ftz;
  assign c_nan  = a_nan | b_nan | (a_inf & (b_zero | ftz_b)) | (b_inf & (a_zero | ftz_a));
  assign c_inf  = a_inf | b_inf;
  assign c_zero = a_zero | b_zero;
  assign c_ftz  = ftz_a | ftz_b;

  logic           s1_sign, s1_nan, s1_inf, s1_zero, s1_ftz;
  logic [XW-1:0]  s1_exp;
  logic [MAN_W:0] s1_ma, s1_mb;
  logic           s2_sign, s2_nan, s2_inf, s2_zero, s2_ftz;
  logic [XW-1:0]  s2_exp;
  logic [PW-1:0]  s2_prod;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
    end else begin
      if (ld1) v1 <= in_valid;
      if (ld2) v2 <= v1;
    end
  end

  always_ff @(posedge clk) begin
    if (ld1 && in_valid) begin
      s1_sign <= sa ^ sb;
      s1_nan  <= c_nan;
      s1_inf  <= c_inf;
      s1_zero <= c_zero;
      s1_ftz  <= c_ftz;
      s1_exp  <= xa + xb - XW'(BIAS);
      s1_ma   <= ma;
      s1_mb   <= mb;
    end
    if (ld2 && v1) begin
      s2_sign <= s1_sign;
      s2_nan  <= s1_nan;
      s2_inf  <= s1_inf;
      s2_zero <= s1_zero;
      s2_ftz  <= s1_ftz;
      s2_exp  <= s1_exp;
      s2_prod <= PW'(s1_ma) * PW'(s1_mb);
    end
  end

  logic [PW-1:0]        norm, sig;
  logic [XW-1:0]        e, ef;
  logic [MAN_W:0]       mh;
  logic [MAN_W+1:0]     r;
  logic                 g, st, inc, tiny, lost;
  logic [EXP_W+MAN_W:0] n_res;
  logic                 n_ovf, n_unf, n_inv, n_inx;
`ifdef FP_MUL_SUBNORMAL_EN
  logic [XW-1:0]        sh;
`endif

  always_comb begin
    norm = s2_prod[PW-1] ? s2_prod : (s2_prod << 1);
    e    = s2_exp + XW'(s2_prod[PW-1]);
    tiny = e[XW-1] || (e == '0);
    sig  = norm;
    lost = 1'b0;
`ifdef FP_MUL_SUBNORMAL_EN
    // Tiny results are denormalised before rounding; shifted-out bits fold into sticky.
    sh = XW'(1) - e;
    if (tiny) begin
      sig  = norm >> sh;
      lost = |(norm & ~({PW{1'b1}} << sh));
    end
`endif
    mh    = sig[PW-1:MAN_W+1];
    g     = sig[MAN_W];
    st    = (|sig[MAN_W-1:0]) | lost;
    inc   = g & (st | mh[0]);
    r     = {1'b0, mh} + {{(MAN_W+1){1'b0}}, inc};
    ef    = e + XW'(r[MAN_W+1]);
    n_res = '0;
    n_ovf = 1'b0;
    n_unf = 1'b0;
    n_inv = 1'b0;
    n_inx = 1'b0;
    if (s2_nan) begin
      n_res = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      n_inv = 1'b1;
    end else if (s2_inf) begin
      n_res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (s2_zero) begin
      n_res = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
    end else if (s2_ftz || tiny) begin
`ifdef FP_MUL_SUBNORMAL_EN
      n_res = {s2_sign, {(EXP_W-1){1'b0}}, r[MAN_W], r[MAN_W-1:0]};
      n_inx = g | st;
      n_unf = g | st;
`else
      n_res = {s2_sign, {(EXP_W+MAN_W){1'b0}}};
      n_inx = 1'b1;
      n_unf = 1'b1;
`endif
    end else if (ef >= XW'(MAXE)) begin
      n_res = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      n_ovf = 1'b1;
      n_inx = 1'b1;
    end else begin
      n_res = {s2_sign, ef[EXP_W-1:0], r[MAN_W-1:0]};
      n_inx = g | st;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
      inexact   <= 1'b0;
    end else if (ld3) begin
      out_valid <= v2;
      if (v2) begin
        result    <= n_res;
        overflow  <= n_ovf;
        underflow <= n_unf;
        invalid   <= n_inv;
        inexact   <= n_inx;
      end
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Directed bench for fp_mul_pipe (single precision): special cases, RNE, backpressure, reset flush.
module tb_fp_mul_pipe;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        in_ready, out_valid, overflow, underflow, invalid, inexact;
  logic [31:0] result;

  int total = 0;
  int bad = 0;

  fp_mul_pipe #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .overflow(overflow), .underflow(underflow), .invalid(invalid), .inexact(inexact)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // flags order: {overflow, underflow, invalid, inexact}
  task automatic run_one(input string tag, input logic [31:0] va, input logic [31:0] vb,
                         input logic [31:0] er, input logic [3:0] ef);
    int lat;
    a = va;
    b = vb;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check($sformatf("%s_rdy", tag), 32'(in_ready), 32'd1);
    tick;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      tick;
      lat++;
    end
    check($sformatf("%s_lat", tag), 32'(lat), 32'd3);
    check($sformatf("%s_res", tag), result, er);
    check($sformatf("%s_flg", tag), 32'({overflow, underflow, invalid, inexact}), 32'(ef));
    tick;
  endtask

  logic [31:0] s_in [6] = '{32'h3F800000, 32'h40000000, 32'h40400000,
                            32'h40800000, 32'h40A00000, 32'h40C00000};
  logic [31:0] s_exp[6] = '{32'h40000000, 32'h40800000, 32'h40C00000,
                            32'h41000000, 32'h41200000, 32'h41400000};

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int sent, got, gaps, stale;
    bit stall, started;

    rst_n = 1'b0;
    tick;
    tick;
    check("rst_ovld", 32'(out_valid), 32'd0);
    check("rst_res", result, 32'h0);
    check("rst_flg", 32'({overflow, underflow, invalid, inexact}), 32'h0);
    rst_n = 1'b1;
    #1;
    check("rst_irdy", 32'(in_ready), 32'd1);
    tick;

    run_one("mul10x-20", 32'h41200000, 32'hC1A00000, 32'hC3480000, 4'b0000);
    run_one("ovf",       32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b1001);
    run_one("inf_x0",    32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b0010);
    run_one("nan_in",    32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'b0010);
    run_one("nan_b",     32'h3F800000, 32'hFF800001, 32'h7FC00000, 4'b0010);
    run_one("n0_xninf",  32'h80000000, 32'hFF800000, 32'h7FC00000, 4'b0010);
    run_one("inf_xneg",  32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000);
    run_one("negzero",   32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000);
    run_one("rne_dn",    32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001);
    run_one("tie_odd",   32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001);
    run_one("tie_even",  32'h3F800003, 32'h3FC00000, 32'h3FC00004, 4'b0001);
    run_one("tiny",      32'h00800000, 32'h00800000, 32'h00000000, 4'b0101);
`ifdef FP_MUL_SUBNORMAL_EN
    run_one("sub_in",    32'h00400000, 32'h40000000, 32'h00800000, 4'b0000);
`else
    run_one("sub_in",    32'h00400000, 32'h40000000, 32'h00000000, 4'b0101);
`endif

    // Backpressure: consumer stalls for the first 8 cycles, then drains.
    sent = 0;
    got = 0;
    gaps = 0;
    stall = 1'b0;
    started = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      in_valid = (sent < 6);
      if (sent < 6) a = s_in[sent];
      b = 32'h40000000;
      out_ready = (cyc >= 8);
      #1;
      if (!out_ready && sent == 3 && !in_ready) stall = 1'b1;
      if (out_valid && out_ready) begin
        check($sformatf("strm%0d", got), result, s_exp[got]);
        got++;
        started = 1'b1;
      end else if (started) begin
        gaps++;
      end
      if (in_valid && in_ready) sent++;
      tick;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("strm_sent", 32'(sent), 32'd6);
    check("strm_got", 32'(got), 32'd6);
    check("strm_gaps", 32'(gaps), 32'd0);
    check("strm_stall", 32'(stall), 32'd1);
    tick;
    tick;

    // Reset with two operations in flight.
    a = 32'h3F800000;
    b = 32'h40000000;
    in_valid = 1'b1;
    tick;
    a = 32'h40400000;
    tick;
    in_valid = 1'b0;
    rst_n = 1'b0;
    tick;
    check("mrst_ovld", 32'(out_valid), 32'd0);
    check("mrst_res", result, 32'h0);
    check("mrst_flg", 32'({overflow, underflow, invalid, inexact}), 32'h0);
    check("mrst_irdy", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    stale = 0;
    repeat (8) begin
      tick;
      if (out_valid) stale++;
    end
    check("mrst_stale", 32'(stale), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
